// File: rtl/alu.sv
// 32-bit ALU (add/sub/shift/logic) with a registered result; one-cycle latency.
// A new operation is accepted every cycle; there is no handshake and no stall.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  aluop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] f
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SLL = 3'b001,
    OP_SRA = 3'b010,
    OP_SUB = 3'b011,
    OP_XOR = 3'b100,
    OP_SRL = 3'b101,
    OP_OR  = 3'b110,
    OP_AND = 3'b111
  } aluop_t;

  logic [4:0]  shamt;
  logic [31:0] result;

  // Only the low five bits of b steer the shifters.
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    unique case (aluop_t'(aluop))
      OP_ADD: result = a + b;
      OP_SLL: result = a << shamt;
      OP_SRA: result = $unsigned($signed(a) >>> shamt);
      OP_SUB: result = a - b;
      OP_XOR: result = a ^ b;
      OP_SRL: result = a >> shamt;
      OP_OR:  result = a | b;
      OP_AND: result = a & b;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f <= '0;
    end else begin
      f <= result;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases followed by randomized
// operations compared against an arithmetic reference model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  aluop;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] f;

  int n_cmp = 0;
  int n_bad = 0;

  alu dut (
    .clk   (clk),
    .rst   (rst),
    .aluop (aluop),
    .a     (a),
    .b     (b),
    .f     (f)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: each operation straight from its arithmetic definition.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x,
                                        input logic [31:0] y);
    int unsigned s;
    logic [31:0] ones;
    logic [31:0] r;
    s    = y % 32;
    ones = 32'hFFFF_FFFF;
    case (op)
      3'd0: r = x + y;
      3'd1: r = x << s;
      3'd2: begin
        r = x >> s;
        if (x[31]) r = r | ~(ones >> s);
      end
      3'd3: r = x - y;
      3'd4: r = x ^ y;
      3'd5: r = x >> s;
      3'd6: r = x | y;
      default: r = x & y;
    endcase
    return r;
  endfunction

  task automatic step(input logic r, input logic [2:0] op, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] exp, input string tag);
    @(negedge clk);
    rst = r; aluop = op; a = x; b = y;
    @(posedge clk);
    #1;
    chk(tag, f, exp);
  endtask

  logic [31:0] sweep_exp [8];

  initial begin
    logic        rr;
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;

    sweep_exp = '{32'h800055AE, 32'h00055AA0, 32'hF800055A, 32'h800055A6,
                  32'h800055AE, 32'h0800055A, 32'h800055AE, 32'h00000000};
    rst = 1'b1; aluop = 3'd0; a = 32'hFFFF_FFFF; b = 32'd1;

    step(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, "reset_edge0");
    step(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, "reset_edge1");

    for (int i = 0; i < 8; i++)
      step(1'b0, 3'(i), 32'h800055AA, 32'h4, sweep_exp[i], $sformatf("sweep_op%0d", i));

    step(1'b0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, "wrap_add");
    step(1'b0, 3'd3, 32'h0, 32'd1, 32'hFFFF_FFFF, "wrap_sub");

    step(1'b0, 3'd2, 32'h8000_0000, 32'h24, 32'hF800_0000, "mask_sra");
    step(1'b0, 3'd5, 32'h8000_0000, 32'h24, 32'h0800_0000, "mask_srl");
    step(1'b0, 3'd1, 32'h8000_0000, 32'h24, 32'h0000_0000, "mask_sll");
    step(1'b0, 3'd2, 32'h8000_0000, 32'h20, 32'h8000_0000, "sh0_sra");
    step(1'b0, 3'd5, 32'h8000_0000, 32'h20, 32'h8000_0000, "sh0_srl");
    step(1'b0, 3'd1, 32'h8000_0000, 32'h20, 32'h8000_0000, "sh0_sll");

    // Inputs changing between edges must not disturb f.
    step(1'b0, 3'd0, 32'd1, 32'd2, 32'd3, "mid_load");
    #2;
    a = 32'd100; b = 32'd200;
    #1;
    chk("mid_hold_early", f, 32'd3);
    @(negedge clk);
    chk("mid_hold_negedge", f, 32'd3);
    @(posedge clk);
    #1;
    chk("mid_new_edge", f, 32'd300);

    // One-cycle reset in the middle of back-to-back adds.
    step(1'b0, 3'd0, 32'd10, 32'd20, 32'd30, "b2b_add0");
    step(1'b1, 3'd0, 32'd11, 32'd21, 32'd0, "b2b_rst");
    step(1'b0, 3'd0, 32'd12, 32'd22, 32'd34, "b2b_add1");
    step(1'b0, 3'd0, 32'd13, 32'd23, 32'd36, "b2b_add2");

    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 15) == 0);
      op = 3'($urandom_range(0, 7));
      x  = $urandom;
      y  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      step(rr, op, x, y, rr ? 32'h0 : model(op, x, y), $sformatf("rand%0d_op%0d", i, op));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end-of-test expected end before 200000");
    $fatal(1);
  end

endmodule
